// File: rtl/cva6_pma_region_checker.sv
// Programmable PMA region checker: NrRules base/length regions, each with
// {lock, nonidem, cached, exec} attributes. Rules are written over a config port.
// NrPorts independent lookup channels each run through a 2-stage valid/ready pipe:
//   S0 holds the match vector plus an attribute snapshot.
//   S1 holds the priority-selected response.
module cva6_pma_region_checker #(
  parameter int unsigned NrRules   = 8,
  parameter int unsigned NrPorts   = 2,
  parameter int unsigned AddrWidth = 64,
  localparam int unsigned IdxW     = (NrRules > 1) ? $clog2(NrRules) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           cfg_we_i,
  input  logic [IdxW-1:0]                cfg_idx_i,
  input  logic [AddrWidth-1:0]           cfg_base_i,
  input  logic [AddrWidth-1:0]           cfg_len_i,
  input  logic [3:0]                     cfg_attr_i,
  output logic                           cfg_err_o,
  input  logic [NrPorts-1:0]             req_valid_i,
  output logic [NrPorts-1:0]             req_ready_o,
  input  logic [NrPorts*AddrWidth-1:0]   req_addr_i,
  output logic [NrPorts-1:0]             resp_valid_o,
  input  logic [NrPorts-1:0]             resp_ready_i,
  output logic [NrPorts-1:0]             resp_hit_o,
  output logic [NrPorts-1:0]             resp_exec_o,
  output logic [NrPorts-1:0]             resp_cached_o,
  output logic [NrPorts-1:0]             resp_nonidem_o
);

  // Rule storage; attr bits are {lock, nonidem, cached, exec}
  logic [AddrWidth-1:0] r_base [NrRules];
  logic [AddrWidth-1:0] r_len  [NrRules];
  logic [3:0]           r_attr [NrRules];
  logic                 r_cfg_err;

  logic                 w_idx_ok;
  logic                 w_cfg_locked;
  logic                 w_cfg_reject;
  logic [AddrWidth:0]   w_end [NrRules];
  logic [NrRules-1:0][2:0] w_attr_all;

  // Pipeline state per port
  logic [NrPorts-1:0]                   r_s0_valid;
  logic [NrPorts-1:0]                   r_s1_valid;
  logic [NrPorts-1:0][NrRules-1:0]      r_s0_match;
  logic [NrPorts-1:0][NrRules-1:0][2:0] r_s0_attr;
  logic [NrPorts-1:0]                   r_hit;
  logic [NrPorts-1:0]                   r_exec;
  logic [NrPorts-1:0]                   r_cached;
  logic [NrPorts-1:0]                   r_nonidem;

  logic [NrPorts-1:0][NrRules-1:0]      w_match;
  logic [NrPorts-1:0]                   w_s1_adv;
  logic [NrPorts-1:0]                   w_req_ready;
  logic [NrPorts-1:0]                   w_accept;
  logic [NrPorts-1:0]                   w_sel_hit;
  logic [NrPorts-1:0]                   w_sel_exec;
  logic [NrPorts-1:0]                   w_sel_cached;
  logic [NrPorts-1:0]                   w_sel_nonidem;

  // Decide whether the current config write is rejected (bad index or locked rule)
  always_comb begin
    w_idx_ok     = (int'(cfg_idx_i) < int'(NrRules));
    w_cfg_locked = 1'b0;
    for (int r = 0; r < int'(NrRules); r++) begin
      if (IdxW'(r) == cfg_idx_i) w_cfg_locked = r_attr[r][3];
    end
    w_cfg_reject = cfg_we_i & (~w_idx_ok | w_cfg_locked);
  end

  // Rule register file and one-cycle reject pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < int'(NrRules); r++) begin
        r_base[r] <= '0;
        r_len[r]  <= '0;
        r_attr[r] <= '0;
      end
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= w_cfg_reject;
      if (cfg_we_i && !w_cfg_reject) begin
        for (int r = 0; r < int'(NrRules); r++) begin
          if (IdxW'(r) == cfg_idx_i) begin
            r_base[r] <= cfg_base_i;
            r_len[r]  <= cfg_len_i;
            r_attr[r] <= cfg_attr_i;
          end
        end
      end
    end
  end

  // Region end at AddrWidth+1 bits so a region ending exactly at 2^AddrWidth does not wrap
  always_comb begin
    for (int r = 0; r < int'(NrRules); r++) begin
      w_end[r]      = {1'b0, r_base[r]} + {1'b0, r_len[r]};
      w_attr_all[r] = r_attr[r][2:0];
    end
  end

  // Compare every port address against every rule
  always_comb begin
    for (int p = 0; p < int'(NrPorts); p++) begin
      for (int r = 0; r < int'(NrRules); r++) begin
        w_match[p][r] = (r_len[r] != '0) &&
                        (req_addr_i[p*AddrWidth +: AddrWidth] >= r_base[r]) &&
                        ({1'b0, req_addr_i[p*AddrWidth +: AddrWidth]} < w_end[r]);
      end
    end
  end

  // Per-port handshake: each stage moves when the next one is empty or draining
  always_comb begin
    w_s1_adv    = ~r_s1_valid | resp_ready_i;
    w_req_ready = ~r_s0_valid | w_s1_adv;
    w_accept    = req_valid_i & w_req_ready;
  end

  // Priority select from the S0 snapshot; lowest index wins, misses default to nonidem
  always_comb begin
    for (int p = 0; p < int'(NrPorts); p++) begin
      w_sel_hit[p]     = 1'b0;
      w_sel_exec[p]    = 1'b0;
      w_sel_cached[p]  = 1'b0;
      w_sel_nonidem[p] = 1'b1;
      for (int r = int'(NrRules) - 1; r >= 0; r--) begin
        if (r_s0_match[p][r]) begin
          w_sel_hit[p] = 1'b1;
          {w_sel_nonidem[p], w_sel_cached[p], w_sel_exec[p]} = r_s0_attr[p][r];
        end
      end
    end
  end

  // Two-stage lookup pipe per port; in-flight entries keep their own rule snapshot
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s0_valid <= '0;
      r_s1_valid <= '0;
      r_s0_match <= '0;
      r_s0_attr  <= '0;
      r_hit      <= '0;
      r_exec     <= '0;
      r_cached   <= '0;
      r_nonidem  <= '0;
    end else begin
      for (int p = 0; p < int'(NrPorts); p++) begin
        if (w_req_ready[p]) r_s0_valid[p] <= req_valid_i[p];
        if (w_accept[p]) begin
          r_s0_match[p] <= w_match[p];
          r_s0_attr[p]  <= w_attr_all;
        end
        if (w_s1_adv[p]) begin
          r_s1_valid[p] <= r_s0_valid[p];
          if (r_s0_valid[p]) begin
            r_hit[p]     <= w_sel_hit[p];
            r_exec[p]    <= w_sel_exec[p];
            r_cached[p]  <= w_sel_cached[p];
            r_nonidem[p] <= w_sel_nonidem[p];
          end
        end
      end
    end
  end

  assign cfg_err_o      = r_cfg_err;
  assign req_ready_o    = w_req_ready;
  assign resp_valid_o   = r_s1_valid;
  assign resp_hit_o     = r_hit;
  assign resp_exec_o    = r_exec;
  assign resp_cached_o  = r_cached;
  assign resp_nonidem_o = r_nonidem;

endmodule
